ghash_sched: RTL and testbench
==============================

Name: ghash_sched

Overview:
- Sequencing controller for the 4-stage pipelined split GF(2^128) multiplier in the GHASH datapath.
- Holds hash key H and drives the four 32-bit H slices to the multiplier.
- Accepts 128-bit AAD/ciphertext blocks over valid/ready and issues (X_i ^ Y_{i-1}) to the multiplier.
- Captures each product after the multiplier latency and returns the final GHASH value Y over valid/ready.

Parameters:
- DATA__WIDTH, 128, block/hash width.
- SPLIT_WIDTH, 32, H slice width; must equal DATA__WIDTH/4.
- MUL_LAT, 4, cycles from mul_a_o presented to mul_res_i valid.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- h_i  in  128  hash key H.
- h_load_i  in  1  load H; honoured in IDLE only.
- start_i  in  1  begin new hash; aborts any operation in progress.
- blk_valid_i  in  1  input block valid.
- blk_ready_o  out  1  block accepted when valid&&ready.
- blk_i  in  128  zero-padded data block.
- blk_last_i  in  1  final data block of message.
- blk_aad_i  in  1  block is AAD (1) or ciphertext (0).
- blk_nbytes_i  in  5  valid bytes, 1..16; 0 treated as 16.
- ha_o/hb_o/hc_o/hd_o  out  32 each  H[127:96], H[95:64], H[63:32], H[31:0].
- mul_a_o  out  128  multiplier operand (a_i).
- mul_flush_o  out  1  multiplier flush.
- mul_res_i  in  128  multiplier product (mul_o).
- hash_valid_o  out  1  hash result valid.
- hash_ready_i  in  1  result consumed.
- hash_o  out  128  GHASH value.

Behaviour:
- Clock and reset: single clk. rst is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; h_q=0; y_q=0; cnt=0.
- h_load_i in IDLE: h_q<=h_i. Ignored in all other states. ha_o..hd_o are always slices of h_q.
- States: IDLE, RUN, ISSUE, WAIT, LEN (feature only), DONE.
- IDLE:
  - start_i -> RUN.
  - Same cycle: mul_flush_o=1, y_q<=0, length counters<=0.
- start_i in any other state: same action, next state RUN. Aborts the current operation; a pending hash result is discarded.
- RUN:
  - blk_ready_o=1.
  - On accept: a_q<=blk_i^y_q; latch last flag; update counters (feature). Next state ISSUE.
- ISSUE (1 cycle): mul_a_o=a_q; cnt<=1; next state WAIT.
- mul_a_o is 0 in every cycle except ISSUE and the LEN issue cycle.
- WAIT:
  - cnt increments each cycle.
  - When cnt==MUL_LAT: y_q<=mul_res_i.
  - Next state: last ? (LEN if feature, else DONE) : RUN.
- Timing:
  - Block accepted at cycle t; operand on mul_a_o at t+1; product sampled at t+1+MUL_LAT.
  - blk_ready_o re-asserts at t+2+MUL_LAT, giving one block per 6 cycles at default MUL_LAT.
- DONE:
  - hash_valid_o=1, hash_o=y_q.
  - Outputs held stable until hash_ready_i; then -> IDLE.
  - start_i together with hash_ready_i: restart wins; the result counts as consumed.
- Counter arithmetic: 64-bit wrapping; bits += nbytes*8.
- A blk_valid_i/blk_last_i protocol error (valid outside RUN) is ignored. Input must be held per valid/ready rules.

Optional Feature:
- GHASH_LEN_BLOCK_EN defined:
  - Controller keeps aad_bits and ct_bits counters.
  - After the last data block it enters LEN and issues {aad_bits,ct_bits}^y_q through the ISSUE/WAIT timing, then -> DONE.
  - The result is the full GHASH including the length block.
- Undefined:
  - No counters and no LEN state; blk_aad_i and blk_nbytes_i are ignored.
  - The caller supplies the length block as an ordinary final block.

Decomposition:
- Shared package ghash_pkg: state enum ghash_state_e; GHASH_W=128; LEN_W=64; default MUL_LAT.
- One natural sub-module: ghash_len_ctr, holding the two 64-bit bit counters and forming the length block; instantiated only under the macro.
- The multiplier is instantiated outside this block, at the GHASH top level.

Test Plan:
- Key and single block: H=66e94bd4ef8a2c3b884cfa59ca342b2e, start, one block C=0388dace60b6a392f328c2b971b2fe78, last, feature off -> hash_o=5e2ec746917062882c85b0685353deb7. Check mul_a_o==C exactly one cycle after accept.
- Same H with feature on: C with nbytes=16, aad=0, last -> LEN block 0x0...080 issued -> hash_o=f38cbb1ad69223dcc3457ae5b6b0f885.
- Throughput and backpressure: 3 back-to-back valid blocks -> blk_ready_o high exactly once per 6 cycles. Hold hash_ready_i low for 10 cycles -> hash_valid_o and hash_o stable.
- Abort: start_i in WAIT cycle 2 -> mul_flush_o pulse, y_q=0. A new single block yields the same result as a fresh run.
- Async reset: assert rst mid-WAIT with no clock edge -> all outputs 0 immediately. h_load_i outside IDLE -> h_q unchanged.
- Empty/partial lengths (feature): AAD block nbytes=0 (=16 bytes) plus a ciphertext block nbytes=5 -> length block {64'd128,64'd40}.

Source files
------------

// File: rtl/ghash_pkg.sv
// Shared types and constants for the GHASH sequencing controller.
package ghash_pkg;

  localparam int GHASH_W     = 128;
  localparam int LEN_W       = 64;
  localparam int MUL_LAT_DEF = 4;

  // State encoding kept as plain constants for compatibility with older tooling.
  typedef logic [2:0] ghash_state_e;
  localparam ghash_state_e S_IDLE  = 3'd0;
  localparam ghash_state_e S_RUN   = 3'd1;
  localparam ghash_state_e S_ISSUE = 3'd2;
  localparam ghash_state_e S_WAIT  = 3'd3;
  localparam ghash_state_e S_LEN   = 3'd4;
  localparam ghash_state_e S_DONE  = 3'd5;

  // A byte count of 0 stands for a full 16-byte block.
  function automatic logic [LEN_W-1:0] nbytes_bits(input logic [4:0] nbytes);
    logic [LEN_W-1:0] n;
    n = (nbytes == 5'd0) ? LEN_W'(16) : LEN_W'(nbytes);
    return n << 3;
  endfunction

endpackage

// File: rtl/ghash_len_ctr.sv
// AAD and ciphertext bit counters; forms the GHASH length block {aad_bits, ct_bits}.
module ghash_len_ctr
  import ghash_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic               aad,
  input  logic [4:0]         nbytes,
  output logic [GHASH_W-1:0] len_blk
);

  logic [LEN_W-1:0] aad_bits_q;
  logic [LEN_W-1:0] ct_bits_q;
  logic [LEN_W-1:0] add_bits;

  assign add_bits = nbytes_bits(nbytes);

  // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aad_bits_q <= '0;
      ct_bits_q  <= '0;
    end else if (clr) begin
      aad_bits_q <= '0;
      ct_bits_q  <= '0;
    end else if (inc) begin
      if (aad) aad_bits_q <= aad_bits_q + add_bits;
      else     ct_bits_q  <= ct_bits_q + add_bits;
    end
  end

  assign len_blk = {aad_bits_q, ct_bits_q};

endmodule

// File: rtl/ghash_sched.sv
// Sequencer for the pipelined split GF(2^128) multiplier of the GHASH datapath.
// Define GHASH_LEN_BLOCK_EN to have the controller count lengths and issue the length block itself.
module ghash_sched
  import ghash_pkg::*;
#(
  parameter int DATA__WIDTH = GHASH_W,
  parameter int SPLIT_WIDTH = GHASH_W / 4,
  parameter int MUL_LAT     = MUL_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA__WIDTH-1:0] h_i,
  input  logic                   h_load_i,
  input  logic                   start_i,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  input  logic [DATA__WIDTH-1:0] blk_i,
  input  logic                   blk_last_i,
  input  logic                   blk_aad_i,
  input  logic [4:0]             blk_nbytes_i,
  output logic [SPLIT_WIDTH-1:0] ha_o,
  output logic [SPLIT_WIDTH-1:0] hb_o,
  output logic [SPLIT_WIDTH-1:0] hc_o,
  output logic [SPLIT_WIDTH-1:0] hd_o,
  output logic [DATA__WIDTH-1:0] mul_a_o,
  output logic                   mul_flush_o,
  input  logic [DATA__WIDTH-1:0] mul_res_i,
  output logic                   hash_valid_o,
  input  logic                   hash_ready_i,
  output logic [DATA__WIDTH-1:0] hash_o
);

  localparam int CNT_W = $clog2(MUL_LAT + 2);

  ghash_state_e           state_q, state_d;
  logic [DATA__WIDTH-1:0] h_q, y_q, a_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   last_q;
  logic                   accept;
  logic                   prod_due;

  // A restart in the same cycle must not swallow a block the sequence is about to drop.
  assign blk_ready_o = (state_q == S_RUN) && !start_i;
  assign accept      = blk_valid_i && blk_ready_o;
  assign prod_due    = (state_q == S_WAIT) && (cnt_q == CNT_W'(MUL_LAT));
  assign mul_flush_o = start_i;

  assign ha_o = h_q[4*SPLIT_WIDTH-1 -: SPLIT_WIDTH];
  assign hb_o = h_q[3*SPLIT_WIDTH-1 -: SPLIT_WIDTH];
  assign hc_o = h_q[2*SPLIT_WIDTH-1 -: SPLIT_WIDTH];
  assign hd_o = h_q[SPLIT_WIDTH-1:0];

  assign hash_valid_o = (state_q == S_DONE);
  assign hash_o       = hash_valid_o ? y_q : '0;

`ifdef GHASH_LEN_BLOCK_EN
  logic [GHASH_W-1:0] len_blk;
  logic               len_q;

  ghash_len_ctr u_len_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_i),
    .inc     (accept),
    .aad     (blk_aad_i),
    .nbytes  (blk_nbytes_i),
    .len_blk (len_blk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    len_q <= 1'b0;
    else if (start_i)           len_q <= 1'b0;
    else if (state_q == S_LEN)  len_q <= 1'b1;
  end
`else
  logic unused_len_in;
  assign unused_len_in = ^{blk_aad_i, blk_nbytes_i};
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mul_a_o = '0;
    if (state_q == S_ISSUE) mul_a_o = a_q;
`ifdef GHASH_LEN_BLOCK_EN
    if (state_q == S_LEN)   mul_a_o = len_blk ^ y_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_RUN:   if (blk_valid_i) state_d = S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (prod_due) begin
`ifdef GHASH_LEN_BLOCK_EN
            if (len_q)       state_d = S_DONE;
            else if (last_q) state_d = S_LEN;
            else             state_d = S_RUN;
`else
            state_d = last_q ? S_DONE : S_RUN;
`endif
          end
        end
`ifdef GHASH_LEN_BLOCK_EN
        S_LEN:   state_d = S_WAIT;
`endif
        S_DONE:  if (hash_ready_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      y_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && h_load_i) h_q <= h_i;
      if (start_i) begin
        y_q    <= '0;
        cnt_q  <= '0;
        last_q <= 1'b0;
      end else begin
        if (accept) begin
          a_q    <= blk_i ^ y_q;
          last_q <= blk_last_i;
        end
        // The LEN cycle issues its operand directly, so it restarts the latency count like ISSUE.
        if (state_q == S_ISSUE || state_q == S_LEN) cnt_q <= CNT_W'(1);
        else if (state_q == S_WAIT)                 cnt_q <= cnt_q + CNT_W'(1);
        if (prod_due) y_q <= mul_res_i;
      end
    end
  end

endmodule

// File: tb/tb_ghash_sched.sv
// Self-checking bench for ghash_sched with a behavioural pipelined GF(2^128) multiplier and GHASH reference.
module tb_ghash_sched;

  localparam int W   = 128;
  localparam int S   = 32;
  localparam int LAT = 4;
`ifdef GHASH_LEN_BLOCK_EN
  localparam int DONE_LAT = 2 * (LAT + 2) - 1;
  localparam logic [W-1:0] KAT_EXP = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
`else
  localparam int DONE_LAT = LAT + 2;
  localparam logic [W-1:0] KAT_EXP = 128'h5e2ec746917062882c85b0685353deb7;
`endif
  localparam logic [W-1:0] KAT_H = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [W-1:0] KAT_C = 128'h0388dace60b6a392f328c2b971b2fe78;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] h_i = '0;
  logic         h_load_i = 1'b0;
  logic         start_i = 1'b0;
  logic         blk_valid_i = 1'b0;
  logic         blk_ready_o;
  logic [W-1:0] blk_i = '0;
  logic         blk_last_i = 1'b0;
  logic         blk_aad_i = 1'b0;
  logic [4:0]   blk_nbytes_i = '0;
  logic [S-1:0] ha_o, hb_o, hc_o, hd_o;
  logic [W-1:0] mul_a_o;
  logic         mul_flush_o;
  logic [W-1:0] mul_res_i;
  logic         hash_valid_o;
  logic         hash_ready_i = 1'b0;
  logic [W-1:0] hash_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ghash_sched #(.DATA__WIDTH(W), .SPLIT_WIDTH(S), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .h_i(h_i), .h_load_i(h_load_i), .start_i(start_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_i(blk_i),
    .blk_last_i(blk_last_i), .blk_aad_i(blk_aad_i), .blk_nbytes_i(blk_nbytes_i),
    .ha_o(ha_o), .hb_o(hb_o), .hc_o(hc_o), .hd_o(hd_o),
    .mul_a_o(mul_a_o), .mul_flush_o(mul_flush_o), .mul_res_i(mul_res_i),
    .hash_valid_o(hash_valid_o), .hash_ready_i(hash_ready_i), .hash_o(hash_o)
  );

  // GCM bit-reflected multiply in GF(2^128).
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] z, v;
    z = '0;
    v = y;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  // External multiplier: LAT register stages fed from mul_a_o and the H slices.
  logic [W-1:0] mpipe [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst || mul_flush_o) begin
      for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= gf_mul(mul_a_o, {ha_o, hb_o, hc_o, hd_o});
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_res_i = mpipe[LAT-1];

  logic [W-1:0] msg_blk [8];
  logic         msg_aad [8];
  logic [4:0]   msg_nb  [8];

  function automatic logic [W-1:0] ref_ghash(input logic [W-1:0] h, input int n);
    logic [W-1:0] y;
    y = '0;
    for (int i = 0; i < n; i++) y = gf_mul(y ^ msg_blk[i], h);
`ifdef GHASH_LEN_BLOCK_EN
    begin
      logic [63:0] ab, cb, nbits;
      ab = '0;
      cb = '0;
      for (int i = 0; i < n; i++) begin
        nbits = ((msg_nb[i] == 5'd0) ? 64'd16 : 64'(msg_nb[i])) * 64'd8;
        if (msg_aad[i]) ab = ab + nbits;
        else            cb = cb + nbits;
      end
      y = gf_mul(y ^ {ab, cb}, h);
    end
`endif
    return y;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic load_h(input logic [W-1:0] h);
    h_i = h;
    h_load_i = 1'b1;
    @(negedge clk);
    h_load_i = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Offers one block, waits for the handshake, then checks the issued operand one cycle later.
  task automatic send_block(input logic [W-1:0] b, input logic last, input logic aad,
                            input logic [4:0] nb, input logic [W-1:0] exp_op, output int acc);
    int n;
    blk_valid_i = 1'b1;
    blk_i = b;
    blk_last_i = last;
    blk_aad_i = aad;
    blk_nbytes_i = nb;
    #1;
    n = 0;
    while (!blk_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!blk_ready_o) begin
      timeout("blk_ready");
      blk_valid_i = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    check("operand_before_issue", mul_a_o, '0);
    @(negedge clk);
    blk_valid_i = 1'b0;
    blk_last_i = 1'b0;
    check("operand_issue", mul_a_o, exp_op);
  endtask

  task automatic wait_valid(output int vc);
    int n;
    n = 0;
    while (!hash_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    vc = hash_valid_o ? cyc : -1;
    if (!hash_valid_o) timeout("hash_valid");
  endtask

  task automatic get_result(input logic [W-1:0] exp, input int hold, output int vc);
    logic [W-1:0] r;
    logic ok;
    wait_valid(vc);
    if (vc < 0) return;
    check("hash", hash_o, exp);
    r = hash_o;
    ok = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!hash_valid_o || hash_o !== r) ok = 1'b0;
    end
    if (hold > 0) check("hash_hold_stable", W'(ok), W'(1));
    hash_ready_i = 1'b1;
    @(negedge clk);
    hash_ready_i = 1'b0;
    check("hash_consumed", W'(hash_valid_o), '0);
  endtask

  task automatic run_msg(input logic [W-1:0] h, input int n, input int hold);
    logic [W-1:0] yp, op;
    int acc, vc;
    load_h(h);
    do_start();
    yp = '0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op = msg_blk[i] ^ yp;
      send_block(msg_blk[i], i == n - 1, msg_aad[i], msg_nb[i], op, acc);
      yp = gf_mul(op, h);
    end
    get_result(ref_ghash(h, n), hold, vc);
  endtask

  function automatic logic [W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    logic [W-1:0] h;
    logic [W-1:0] blk;
    logic         aad;
    logic [4:0]   nb;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] hk, yp, op, b1, b2;
    int acc, vc;
    int accs [3];

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_h", {ha_o, hb_o, hc_o, hd_o}, '0);
    check("reset_mul_a", mul_a_o, '0);
    check("reset_hash", hash_o, '0);
    check("reset_ctl", W'({blk_ready_o, mul_flush_o, hash_valid_o}), '0);
    rst = 1'b0;
    @(negedge clk);

    // Single-block vector table: known-answer case first, then random keys/blocks.
    tbl[0] = '{h: KAT_H, blk: KAT_C, aad: 1'b0, nb: 5'd16, exp: KAT_EXP};
    for (int i = 1; i < 5; i++) begin
      tbl[i].h   = rand128();
      tbl[i].blk = rand128();
      tbl[i].aad = 1'($urandom_range(0, 1));
      tbl[i].nb  = 5'($urandom_range(0, 16));
      msg_blk[0] = tbl[i].blk;
      msg_aad[0] = tbl[i].aad;
      msg_nb[0]  = tbl[i].nb;
      tbl[i].exp = ref_ghash(tbl[i].h, 1);
    end
    for (int i = 0; i < 5; i++) begin
      load_h(tbl[i].h);
      check("h_slices", {ha_o, hb_o, hc_o, hd_o}, tbl[i].h);
      do_start();
      send_block(tbl[i].blk, 1'b1, tbl[i].aad, tbl[i].nb, tbl[i].blk, acc);
      get_result(tbl[i].exp, 0, vc);
    end

    // Throughput, result latency and result hold under backpressure.
    hk = rand128();
    for (int i = 0; i < 3; i++) begin
      msg_blk[i] = rand128();
      msg_aad[i] = 1'b0;
      msg_nb[i]  = 5'd16;
    end
    load_h(hk);
    do_start();
    yp = '0;
    for (int i = 0; i < 3; i++) begin
      op = msg_blk[i] ^ yp;
      send_block(msg_blk[i], i == 2, 1'b0, 5'd16, op, accs[i]);
      yp = gf_mul(op, hk);
    end
    check("ready_period_0", W'(accs[1] - accs[0]), W'(LAT + 2));
    check("ready_period_1", W'(accs[2] - accs[1]), W'(LAT + 2));
    get_result(ref_ghash(hk, 3), 10, vc);
    check("done_latency", W'(vc - accs[2]), W'(DONE_LAT));

    // Abort in the second WAIT cycle, then a fresh single block.
    b1 = rand128();
    msg_blk[0] = KAT_C;
    msg_aad[0] = 1'b0;
    msg_nb[0]  = 5'd16;
    load_h(KAT_H);
    do_start();
    send_block(b1, 1'b0, 1'b0, 5'd16, b1, acc);
    repeat (2) @(negedge clk);
    start_i = 1'b1;
    #1;
    check("abort_flush", W'(mul_flush_o), W'(1));
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check("abort_flush_end", W'(mul_flush_o), '0);
    send_block(KAT_C, 1'b1, 1'b0, 5'd16, KAT_C, acc);
    get_result(KAT_EXP, 0, vc);

    // Restart together with result consumption: restart wins.
    hk = rand128();
    b1 = rand128();
    b2 = rand128();
    load_h(hk);
    do_start();
    send_block(b1, 1'b1, 1'b0, 5'd16, b1, acc);
    wait_valid(vc);
    start_i = 1'b1;
    hash_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    hash_ready_i = 1'b0;
    #1;
    check("restart_valid_drop", W'(hash_valid_o), '0);
    check("restart_ready", W'(blk_ready_o), W'(1));
    msg_blk[0] = b2;
    send_block(b2, 1'b1, 1'b0, 5'd16, b2, acc);
    get_result(ref_ghash(hk, 1), 0, vc);

    // Key load outside IDLE is ignored.
    hk = rand128();
    b1 = rand128();
    msg_blk[0] = b1;
    load_h(hk);
    do_start();
    h_i = ~hk;
    h_load_i = 1'b1;
    send_block(b1, 1'b1, 1'b0, 5'd16, b1, acc);
    @(negedge clk);
    h_load_i = 1'b0;
    check("hload_ignored", {ha_o, hb_o, hc_o, hd_o}, hk);
    get_result(ref_ghash(hk, 1), 0, vc);

    // Asynchronous reset in the middle of WAIT, away from any clock edge.
    load_h(rand128());
    do_start();
    b1 = rand128();
    send_block(b1, 1'b1, 1'b0, 5'd16, b1, acc);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_h", {ha_o, hb_o, hc_o, hd_o}, '0);
    check("async_rst_mul_a", mul_a_o, '0);
    check("async_rst_hash", hash_o, '0);
    check("async_rst_ctl", W'({blk_ready_o, mul_flush_o, hash_valid_o}), '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full AAD block (nbytes=0) followed by a 5-byte ciphertext block.
    hk = rand128();
    msg_blk[0] = rand128();
    msg_aad[0] = 1'b1;
    msg_nb[0]  = 5'd0;
    msg_blk[1] = {rand128()} & {{40{1'b1}}, 88'h0};
    msg_aad[1] = 1'b0;
    msg_nb[1]  = 5'd5;
`ifdef GHASH_LEN_BLOCK_EN
    load_h(hk);
    do_start();
    op = msg_blk[0];
    send_block(msg_blk[0], 1'b0, 1'b1, 5'd0, op, acc);
    yp = gf_mul(op, hk);
    op = msg_blk[1] ^ yp;
    send_block(msg_blk[1], 1'b1, 1'b0, 5'd5, op, acc);
    yp = gf_mul(op, hk);
    repeat (LAT + 1) @(negedge clk);
    check("len_operand", mul_a_o, {64'd128, 64'd40} ^ yp);
    get_result(ref_ghash(hk, 2), 0, vc);
`else
    run_msg(hk, 2, 0);
`endif

    // Random multi-block messages with random idle gaps and result backpressure.
    for (int m = 0; m < 12; m++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        msg_blk[i] = rand128();
        msg_aad[i] = 1'($urandom_range(0, 1));
        msg_nb[i]  = 5'($urandom_range(0, 16));
      end
      run_msg(rand128(), n, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
